// File: rtl/tiny_mind_pkg.sv
// Shared state encoding for the tiny_mind run-once counter FSM.
package tiny_mind_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/tiny_mind_if.sv
// Status bundle of tiny_mind: the core drives it, observers read it.
interface tiny_mind_if #(
   parameter int CNT_W = 4
);
   import tiny_mind_pkg::*;

   logic             done_r;
   logic             busy_r;
   logic [CNT_W-1:0] count_r;
   logic [STATE_W-1:0] state_o;

   modport master (output done_r, output busy_r, output count_r, output state_o);
   modport slave  (input  done_r, input  busy_r, input  count_r, input  state_o);
endinterface

// File: rtl/tiny_mind_counter.sv
// Saturating up-counter with synchronous clear and terminal-count flag.
module tiny_mind_counter #(
   parameter int MAX_VALUE = 14,
   parameter int CNT_W     = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             at_max
);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_VALUE);

   assign at_max = (count == MAX_CNT);

   // Holding at the terminal value is what keeps the count from ever wrapping.
   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (en && !at_max) begin
         count <= count + 1'b1;
      end
   end
endmodule

// File: rtl/tiny_mind.sv
// Run-once counter: IDLE -> RUN counts up to MAX_VALUE -> DONE until reset.
module tiny_mind
   import tiny_mind_pkg::*;
#(
   parameter int MAX_VALUE = 14,
   parameter int CNT_W     = (MAX_VALUE < 1) ? 1 : $clog2(MAX_VALUE + 1)
) (
   input  logic        clk,
   input  logic        rst,
   tiny_mind_if.master bus
);
   state_t state_q;
   state_t state_d;
   logic   done_q;
   logic   done_d;
   logic   busy_q;
   logic   busy_d;
   logic   at_max;
   logic   cnt_clr;
   logic   cnt_en;

   // Count survives only while running or parked in DONE; IDLE and the illegal code clear it.
   assign cnt_clr = rst || !((state_q == RUN) || (state_q == DONE));
   assign cnt_en  = (state_q == RUN);

   tiny_mind_counter #(
      .MAX_VALUE (MAX_VALUE),
      .CNT_W     (CNT_W)
   ) u_counter (
      .clk    (clk),
      .clr    (cnt_clr),
      .en     (cnt_en),
      .count  (bus.count_r),
      .at_max (at_max)
   );

   always_comb begin
      state_d = IDLE;
      done_d  = done_q;
      busy_d  = busy_q;
      case (state_q)
         IDLE: begin
            state_d = RUN;
            busy_d  = 1'b1;
            done_d  = 1'b0;
         end
         RUN: begin
            if (at_max) begin
               state_d = DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               state_d = RUN;
            end
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
            done_d  = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.done_r  = done_q;
   assign bus.busy_r  = busy_q;
   assign bus.state_o = state_q;
endmodule

// File: tb/tb_tiny_mind.sv
// Directed bench for tiny_mind with MAX_VALUE = 14, 0 and 15 run side by side.
module tb_tiny_mind;
   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   tiny_mind_if #(.CNT_W(4)) b14 ();
   tiny_mind_if #(.CNT_W(1)) b0  ();
   tiny_mind_if #(.CNT_W(4)) b15 ();

   tiny_mind #(.MAX_VALUE(14))             u14 (.clk(clk), .rst(rst), .bus(b14));
   tiny_mind #(.MAX_VALUE(0))              u0  (.clk(clk), .rst(rst), .bus(b0));
   tiny_mind #(.MAX_VALUE(15), .CNT_W(4))  u15 (.clk(clk), .rst(rst), .bus(b15));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected outputs after edge e (e counted from the first edge with rst=0).
   task automatic check_dut(input string name, input int max, input int e,
                            input logic [31:0] cnt, input logic done, input logic busy,
                            input logic [1:0] st);
      int  exp_cnt;
      logic exp_done;
      exp_cnt  = (e <= 1) ? 0 : ((e - 1 > max) ? max : e - 1);
      exp_done = (e >= max + 2);
      check($sformatf("%s_cnt_e%0d", name, e), cnt, exp_cnt);
      check($sformatf("%s_done_e%0d", name, e), {31'd0, done}, {31'd0, exp_done});
      check($sformatf("%s_busy_e%0d", name, e), {31'd0, busy}, {31'd0, !exp_done});
      check($sformatf("%s_state_e%0d", name, e), {30'd0, st}, exp_done ? 32'd2 : 32'd1);
      check($sformatf("%s_excl_e%0d", name, e), {31'd0, done & busy}, 32'd0);
   endtask

   task automatic run_edges(input int first, input int last);
      for (int e = first; e <= last; e++) begin
         tick();
         check_dut("m14", 14, e, {28'd0, b14.count_r}, b14.done_r, b14.busy_r, b14.state_o);
         check_dut("m0",  0,  e, {31'd0, b0.count_r},  b0.done_r,  b0.busy_r,  b0.state_o);
         check_dut("m15", 15, e, {28'd0, b15.count_r}, b15.done_r, b15.busy_r, b15.state_o);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_m14"}, {b14.state_o, b14.done_r, b14.busy_r, b14.count_r}, 32'd0);
      check({tag, "_m0"},  {b0.state_o,  b0.done_r,  b0.busy_r,  b0.count_r},  32'd0);
      check({tag, "_m15"}, {b15.state_o, b15.done_r, b15.busy_r, b15.count_r}, 32'd0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      repeat (3) tick();
      check_reset("por");

      // First full run, then 100 further edges parked in DONE.
      rst = 1'b0;
      run_edges(1, 15);
      check("m14_pre_done", {31'd0, b14.done_r}, 32'd0);
      run_edges(16, 17);
      check("m14_final_cnt", {28'd0, b14.count_r}, 32'd14);
      check("m15_final_cnt", {28'd0, b15.count_r}, 32'd15);
      run_edges(18, 117);

      // Reset held 5 cycles from DONE, then a fresh run.
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_reset($sformatf("hold%0d", i));
      end
      rst = 1'b0;
      run_edges(1, 20);

      // Abort mid-run at count 7, then a fresh run.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      run_edges(1, 8);
      check("m14_at7", {28'd0, b14.count_r}, 32'd7);
      rst = 1'b1;
      tick();
      check_reset("abort");
      rst = 1'b0;
      run_edges(1, 20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/tiny_mind.md
TINY_MIND -- requirements
Module: tiny_mind

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter MAX_VALUE, default 14, SHALL set the terminal count value; legal range 0..65535.
REQ-003 Parameter CNT_W, default max(1, clog2(MAX_VALUE+1)), SHALL set the counter width.
REQ-004 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port done_r, output, 1 bit: registered completion flag, sticky until reset.
REQ-007 Port busy_r, output, 1 bit: registered, high while counting.
REQ-008 Port count_r, output, CNT_W bits: registered current count.
REQ-009 Port state_o, output, 2 bits: current FSM state encoding, for debug.

Function
REQ-010 The FSM SHALL have states IDLE=2'b00, RUN=2'b01, DONE=2'b10; 2'b11 is illegal.
REQ-011 IDLE: on the next rising edge with rst=0, the FSM SHALL go to RUN with count_r held at 0 and busy_r set to 1.
REQ-012 RUN, count_r != MAX_VALUE: count_r SHALL increment by 1 per edge.
REQ-013 RUN, count_r == MAX_VALUE: the FSM SHALL go to DONE, set done_r=1 and busy_r=0, and hold count_r at MAX_VALUE.
REQ-014 DONE: all outputs SHALL hold; DONE is exited only by reset.
REQ-015 Latency: done_r SHALL rise on rising edge number MAX_VALUE+2 after the first edge sampling rst=0 (edge 16 for MAX_VALUE=14).
REQ-016 count_r SHALL never exceed MAX_VALUE and SHALL never wrap.
REQ-017 MAX_VALUE=0: the FSM SHALL go IDLE -> RUN -> DONE, with done_r rising on edge 2.
REQ-018 Illegal state 2'b11 SHALL recover to IDLE on the next edge, with count_r=0, done_r=0, busy_r=0.
REQ-019 done_r and busy_r SHALL never be high simultaneously.
REQ-020 All outputs SHALL be direct flop outputs, with no combinational path from inputs.

Reset
REQ-021 Any edge with rst=1 SHALL force state=IDLE, count_r=0, done_r=0, busy_r=0, regardless of current state.
REQ-022 Reset asserted mid-RUN or in DONE SHALL abort the run; after release, a complete fresh run SHALL occur with identical latency.
REQ-023 Reset held for multiple cycles SHALL keep all outputs at their reset values.
REQ-024 Behaviour before the first reset is undefined; the bench SHALL apply reset first.

Structure
REQ-025 A shared package tiny_mind_pkg SHALL hold the state typedef (IDLE/RUN/DONE encodings) and the state width constant.
REQ-026 One sub-module, tiny_mind_counter, SHALL implement the saturating up-counter, with clear, enable, terminal-count compare output and CNT_W parameter.
REQ-027 The top level SHALL contain the FSM, the done/busy flops and the counter instance.

Verification
REQ-028 MAX_VALUE=14: release reset and count edges -> done_r rises on edge 16, count_r=14, busy_r=0.
REQ-029 After done_r, assert rst for 5 cycles then release -> outputs are 0 during reset; done_r rises again on edge 16 after release.
REQ-030 Assert rst when count_r=7 during RUN -> next edge gives count_r=0 and state IDLE; the full 16-edge run repeats.
REQ-031 MAX_VALUE=0 -> done_r rises on edge 2, and count_r stays 0 throughout.
REQ-032 MAX_VALUE=15, CNT_W=4 -> count_r reaches 15 with no wrap, done_r rises on edge 17, and done_r and busy_r are never both high.
REQ-033 Hold 100 edges in DONE -> done_r=1 and count_r=MAX_VALUE remain stable with no state change.
